dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter: LINES, 16, number of direct-mapped lines (power of 2, 4..256).
REQ-002 Parameter: MEM_W, 128, backing-memory block width in bits (4 words, 16 B).
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 cpu_req_i  in  1  CPU access request (MemRead or MemWrite active).
REQ-007 cpu_we_i  in  1  1 = store word, 0 = load word.
REQ-008 cpu_addr_i  in  32  byte address; [1:0] ignored.
REQ-009 cpu_wdata_i  in  32  store data.
REQ-010 cpu_rdata_o  out  32  load data; valid when cpu_req_i=1, cpu_we_i=0 and stall_o=0.
REQ-011 stall_o  out  1  freezes the CPU; CPU holds req/we/addr/wdata stable while high.
REQ-012 mem_req_o  out  1  backing-memory request.
REQ-013 mem_we_o  out  1  1 = block write-back, 0 = block fill.
REQ-014 mem_addr_o  out  32  block-aligned address; [3:0]=0.
REQ-015 mem_wdata_o  out  MEM_W  victim block.
REQ-016 mem_rdata_i  in  MEM_W  fill block; sampled on mem_ack_i.
REQ-017 mem_ack_i  in  1  one-cycle completion pulse from memory.
REQ-018 hit_cnt_o  out  32  count of first-attempt hits.
REQ-019 miss_cnt_o  out  32  count of misses.

Function
REQ-020 Address split: offset [3:0], word select [3:2], index [3+log2(LINES):4], tag = remaining upper bits.
REQ-021 Policy: direct-mapped, write-back, write-allocate; per line: valid, dirty, tag, 4 data words.
REQ-022 hit = valid[index] & (tag[index] == addr tag), evaluated combinationally in IDLE.
REQ-023 States: IDLE, WRITEBACK, ALLOCATE.
REQ-024 stall_o = cpu_req_i & (state != IDLE | !hit), combinational.
REQ-025 IDLE, read hit: cpu_rdata_o = selected word, same cycle, zero-wait.
REQ-026 IDLE, write hit: selected word written and dirty set on the same rising edge.
REQ-027 IDLE, miss: victim dirty & valid -> WRITEBACK; otherwise -> ALLOCATE.
REQ-028 WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o = {victim tag, index, 4'b0}, mem_wdata_o = victim block; on mem_ack_i -> ALLOCATE, dirty cleared.
REQ-029 ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o = {req tag, index, 4'b0}; on mem_ack_i the line is loaded, tag written, valid=1, dirty=0 -> IDLE.
REQ-030 After ALLOCATE the held request replays in IDLE as a hit; a store replay sets dirty.
REQ-031 mem_req_o stays high, with address and data stable, until mem_ack_i; it is low in IDLE.
REQ-032 mem_ack_i in IDLE is ignored.
REQ-033 miss_cnt_o increments once per IDLE->WRITEBACK/ALLOCATE transition.
REQ-034 hit_cnt_o increments on an IDLE hit only when the internal replay flag is clear; the flag is set on a miss and cleared on the replay hit.
REQ-035 Both counters saturate at 32'hFFFF_FFFF.
REQ-036 cpu_req_i=0 in IDLE: no state change, stall_o=0, counters unchanged.

Reset
REQ-037 rst_i=1 forces, asynchronously: state=IDLE, all valid/dirty=0, all tags=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, counters=0, replay flag=0.
REQ-038 Reset mid-WRITEBACK or mid-ALLOCATE abandons the transaction; a mem_ack_i arriving after reset release is ignored.
REQ-039 cpu_rdata_o=0 and stall_o=0 during reset; data words need not be cleared.

Structure
REQ-040 Shared package dcache_pkg: state enum, word/block widths, offset width, and the default for LINES.
REQ-041 Sub-module dcache_line_store holds the valid/dirty/tag/data arrays, with a word-write port and a block-fill port; dcache_ctrl holds the FSM and counters.

Verification
REQ-042 Cold read 0x0000_0040, memory acks after 3 cycles -> stall_o high 4+ cycles, mem_addr_o=0x40, then read data returned; miss_cnt_o=1, hit_cnt_o=0.
REQ-043 Repeat read 0x44 after the fill -> zero stall, word 1 of the block returned, hit_cnt_o=1.
REQ-044 Store 0xDEADBEEF to 0x40, then read 0x0000_1040 (same index, different tag) -> WRITEBACK to 0x40 with word 0 = 0xDEADBEEF, then ALLOCATE from 0x1040.
REQ-045 Clean-victim miss -> no WRITEBACK state; a single mem_req_o with mem_we_o=0.
REQ-046 Assert rst_i during ALLOCATE, then send a late mem_ack_i -> mem_req_o=0 immediately, state IDLE, read 0x40 misses, counters start from 0.
REQ-047 Force miss_cnt_o to 32'hFFFF_FFFF, then force a miss -> value holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BLOCK_W       = 128;
  localparam int unsigned OFFSET_W      = 4;
  localparam int unsigned WSEL_W        = 2;
  localparam int unsigned LINES_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (v == {WORD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays for the cache, with a CPU word-write port and a
// memory block-fill port. Data words are not reset; only the metadata is.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEFAULT,
  parameter int unsigned MEM_W = BLOCK_W,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned TAG_W = WORD_W - OFFSET_W - IDX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [MEM_W-1:0]  block_o,
  input  logic              wr_en_i,
  input  logic [WSEL_W-1:0] wr_sel_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              fill_en_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [MEM_W-1:0]  fill_data_i,
  input  logic              clean_i
);

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [MEM_W-1:0] r_data [LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < int'(LINES); i++) begin
        r_tag[i] <= '0;
      end
    end else if (fill_en_i) begin
      r_valid[idx_i] <= 1'b1;
      r_dirty[idx_i] <= 1'b0;
      r_tag[idx_i]   <= fill_tag_i;
    end else if (wr_en_i) begin
      r_dirty[idx_i] <= 1'b1;
    end else if (clean_i) begin
      r_dirty[idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      r_data[idx_i] <= fill_data_i;
    end else if (wr_en_i) begin
      r_data[idx_i][wr_sel_i*WORD_W +: WORD_W] <= wr_data_i;
    end
  end

  assign valid_o = r_valid[idx_i];
  assign dirty_o = r_dirty[idx_i];
  assign tag_o   = r_tag[idx_i];
  assign block_o = r_data[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller: hit
// detection, miss FSM (writeback then allocate) and saturating hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEFAULT,
  parameter int unsigned MEM_W = BLOCK_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [MEM_W-1:0]  mem_wdata_o,
  input  logic [MEM_W-1:0]  mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = WORD_W - OFFSET_W - IDX_W;

  state_e             r_state;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [MEM_W-1:0]   r_mem_wdata;
  logic [31:0]        r_hit_cnt;
  logic [31:0]        r_miss_cnt;
  logic               r_replay;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [WSEL_W-1:0]  w_sel;
  logic               w_valid;
  logic               w_dirty;
  logic [TAG_W-1:0]   w_vtag;
  logic [MEM_W-1:0]   w_block;
  logic               w_idle;
  logic               w_hit;
  logic               w_wr_en;
  logic               w_fill_en;
  logic               w_clean;
  logic [31:0]        w_word;
  logic [1:0]         w_unused_addr;

  assign w_idx         = cpu_addr_i[OFFSET_W +: IDX_W];
  assign w_tag         = cpu_addr_i[31 -: TAG_W];
  assign w_sel         = cpu_addr_i[3:2];
  assign w_unused_addr = cpu_addr_i[1:0];

  assign w_idle    = (r_state == StIdle);
  assign w_hit     = w_idle & w_valid & (w_vtag == w_tag);
  assign w_wr_en   = cpu_req_i & cpu_we_i & w_hit;
  assign w_fill_en = (r_state == StAllocate) & mem_ack_i;
  assign w_clean   = (r_state == StWriteback) & mem_ack_i;
  assign w_word    = w_block[w_sel*WORD_W +: WORD_W];

  assign stall_o     = ~rst_i & cpu_req_i & (~w_idle | ~w_hit);
  assign cpu_rdata_o = (~rst_i & cpu_req_i & ~cpu_we_i & ~stall_o) ? w_word : '0;

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign hit_cnt_o   = r_hit_cnt;
  assign miss_cnt_o  = r_miss_cnt;

  dcache_line_store #(
    .LINES (LINES),
    .MEM_W (MEM_W)
  ) u_store (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (w_idx),
    .valid_o     (w_valid),
    .dirty_o     (w_dirty),
    .tag_o       (w_vtag),
    .block_o     (w_block),
    .wr_en_i     (w_wr_en),
    .wr_sel_i    (w_sel),
    .wr_data_i   (cpu_wdata_i),
    .fill_en_i   (w_fill_en),
    .fill_tag_i  (w_tag),
    .fill_data_i (mem_rdata_i),
    .clean_i     (w_clean)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_replay    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cpu_req_i) begin
            if (w_hit) begin
              // The hit that replays a just-filled miss is not a first-attempt hit.
              if (!r_replay) r_hit_cnt <= sat_inc(r_hit_cnt);
              r_replay <= 1'b0;
            end else begin
              r_miss_cnt <= sat_inc(r_miss_cnt);
              r_replay   <= 1'b1;
              r_mem_req  <= 1'b1;
              if (w_valid && w_dirty) begin
                r_state     <= StWriteback;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= {w_vtag, w_idx, {OFFSET_W{1'b0}}};
                r_mem_wdata <= w_block;
              end else begin
                r_state    <= StAllocate;
                r_mem_we   <= 1'b0;
                r_mem_addr <= {w_tag, w_idx, {OFFSET_W{1'b0}}};
              end
            end
          end
        end
        StWriteback: begin
          if (mem_ack_i) begin
            r_state    <= StAllocate;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_idx, {OFFSET_W{1'b0}}};
          end
        end
        StAllocate: begin
          if (mem_ack_i) begin
            r_state   <= StIdle;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic
// checked against a block-residency model and a flat shadow of CPU-visible memory.
module tb_dcache_ctrl;

  localparam int unsigned LINES = 16;
  localparam int unsigned MEM_W = 128;

  logic             clk;
  logic             rst;
  logic             cpu_req;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             stall;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [MEM_W-1:0] mem_wdata;
  logic [MEM_W-1:0] mem_rdata;
  logic             mem_ack;
  logic [31:0]      hit_cnt;
  logic [31:0]      miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit               we;
    logic [31:0]      addr;
    logic [MEM_W-1:0] data;
  } txn_t;

  txn_t             txq[$];
  logic [MEM_W-1:0] mem_blk [logic [31:0]];
  logic [31:0]      shadow  [logic [31:0]];
  int               ack_delay = 3;
  bit               resp_en   = 1'b1;

  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  logic [31:0] m_blk   [LINES];
  int unsigned m_hits;
  int unsigned m_misses;

  dcache_ctrl #(
    .LINES (LINES),
    .MEM_W (MEM_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .stall_o     (stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [MEM_W-1:0] mem_rd(input logic [31:0] a);
    logic [MEM_W-1:0] b;
    if (mem_blk.exists(a)) return mem_blk[a];
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = (a + 32'(k * 4)) ^ 32'hC0DE_0000;
    return b;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0]      w;
    logic [MEM_W-1:0] b;
    w = {a[31:2], 2'b00};
    if (shadow.exists(w)) return shadow[w];
    b = mem_rd({a[31:4], 4'b0000});
    return b[a[3:2]*32 +: 32];
  endfunction

  function automatic logic [MEM_W-1:0] ref_block(input logic [31:0] a);
    logic [MEM_W-1:0] b;
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = ref_word(a + 32'(k * 4));
    return b;
  endfunction

  // Predicts one CPU access: residency, victim write-back, and load data.
  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              output bit hit, output bit wb, output logic [31:0] wb_addr,
                              output logic [MEM_W-1:0] wb_data, output logic [31:0] exp_rd);
    int          idx;
    logic [31:0] blk;
    idx     = int'((addr >> 4) % LINES);
    blk     = {addr[31:4], 4'b0000};
    exp_rd  = ref_word(addr);
    wb      = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    hit     = m_valid[idx] && (m_blk[idx] == blk);
    if (hit) begin
      m_hits++;
    end else begin
      m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        wb      = 1'b1;
        wb_addr = m_blk[idx];
        wb_data = ref_block(m_blk[idx]);
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_blk[idx]   = blk;
    end
    if (we) begin
      m_dirty[idx] = 1'b1;
      shadow[{addr[31:2], 2'b00}] = wd;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(LINES); i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_blk[i]   = '0;
    end
    m_hits   = 0;
    m_misses = 0;
    shadow.delete();
  endtask

  // Drives one CPU access, holding it while stalled; returns load data and stall cycles.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int stalls, output bit to);
    txq.delete();
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    stalls    = 0;
    to        = 1'b0;
    #1;
    while (stall === 1'b1) begin
      stalls++;
      if (stalls > 200) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    rd = cpu_rdata;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  initial begin : responder
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        mem_ack = 1'b0;
        if (mem_req === 1'b1 && !rst) begin
          wait_cnt++;
          if (wait_cnt >= ack_delay) begin
            txq.push_back('{mem_we, mem_addr, mem_wdata});
            if (mem_we) mem_blk[mem_addr] = mem_wdata;
            else        mem_rdata = mem_rd(mem_addr);
            mem_ack  = 1'b1;
            wait_cnt = 0;
          end
        end else begin
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cpu_outs: stall=%b rdata=%h, required 0 and 0", stall, cpu_rdata);
    end
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_outs: req=%b we=%b addr=%h, required all 0", mem_req, mem_we,
               mem_addr);
    end
    n_checks++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, required 0 0", hit_cnt, miss_cnt);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_read();
    logic [31:0] rd, exp_rd, wa;
    logic [MEM_W-1:0] wdat;
    bit hit, wb, to;
    int stalls;
    ack_delay = 3;
    model_access(1'b0, 32'h40, 32'h0, hit, wb, wa, wdat, exp_rd);
    access(1'b0, 32'h40, 32'h0, rd, stalls, to);
    n_checks++;
    if (to || stalls < 4) begin
      n_fail++;
      $display("FAIL cold_stall: stalled %0d cycles (timeout=%b), required >= 4", stalls, to);
    end
    n_checks++;
    if (txq.size() != 1 || txq[0].we != 1'b0 || txq[0].addr !== 32'h40) begin
      n_fail++;
      $display("FAIL cold_fill: %0d mem txns, required one fill of 00000040", txq.size());
    end
    n_checks++;
    if (rd !== exp_rd) begin
      n_fail++;
      $display("FAIL cold_rdata: got %h, required %h", rd, exp_rd);
    end
    n_checks++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL cold_counters: hit=%0d miss=%0d, required 0 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_hit();
    logic [31:0] rd, exp_rd, wa;
    logic [MEM_W-1:0] wdat;
    bit hit, wb, to;
    int stalls;
    model_access(1'b0, 32'h44, 32'h0, hit, wb, wa, wdat, exp_rd);
    access(1'b0, 32'h44, 32'h0, rd, stalls, to);
    n_checks++;
    if (to || stalls != 0 || txq.size() != 0) begin
      n_fail++;
      $display("FAIL hit_no_stall: stalled %0d, %0d mem txns, required 0 0", stalls, txq.size());
    end
    n_checks++;
    if (rd !== exp_rd) begin
      n_fail++;
      $display("FAIL hit_rdata: got %h, required %h", rd, exp_rd);
    end
    n_checks++;
    if (hit_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL hit_count: got %0d, required 1", hit_cnt);
    end
  endtask

  task automatic test_writeback();
    logic [31:0] rd, exp_rd, wa;
    logic [MEM_W-1:0] wdat;
    bit hit, wb, to;
    int stalls;
    model_access(1'b1, 32'h40, 32'hDEAD_BEEF, hit, wb, wa, wdat, exp_rd);
    access(1'b1, 32'h40, 32'hDEAD_BEEF, rd, stalls, to);
    n_checks++;
    if (to || stalls != 0) begin
      n_fail++;
      $display("FAIL store_hit_stall: stalled %0d, required 0", stalls);
    end
    model_access(1'b0, 32'h1040, 32'h0, hit, wb, wa, wdat, exp_rd);
    access(1'b0, 32'h1040, 32'h0, rd, stalls, to);
    n_checks++;
    if (to || txq.size() != 2) begin
      n_fail++;
      $display("FAIL wb_txn_count: got %0d mem txns, required 2", txq.size());
    end else begin
      n_checks++;
      if (txq[0].we != 1'b1 || txq[0].addr !== 32'h40 || txq[0].data[31:0] !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL wb_victim: we=%b addr=%h word0=%h, required 1 00000040 deadbeef",
                 txq[0].we, txq[0].addr, txq[0].data[31:0]);
      end
      n_checks++;
      if (txq[0].data !== wdat) begin
        n_fail++;
        $display("FAIL wb_block: got %h, required %h", txq[0].data, wdat);
      end
      n_checks++;
      if (txq[1].we != 1'b0 || txq[1].addr !== 32'h1040) begin
        n_fail++;
        $display("FAIL wb_then_fill: we=%b addr=%h, required 0 00001040", txq[1].we, txq[1].addr);
      end
    end
    n_checks++;
    if (rd !== exp_rd) begin
      n_fail++;
      $display("FAIL wb_rdata: got %h, required %h", rd, exp_rd);
    end
  endtask

  task automatic test_clean_miss();
    logic [31:0] rd, exp_rd, wa;
    logic [MEM_W-1:0] wdat;
    bit hit, wb, to;
    int stalls;
    ack_delay = 2;
    model_access(1'b0, 32'h2048, 32'h0, hit, wb, wa, wdat, exp_rd);
    access(1'b0, 32'h2048, 32'h0, rd, stalls, to);
    n_checks++;
    if (to || txq.size() != 1 || txq[0].we != 1'b0 || txq[0].addr !== 32'h2040) begin
      n_fail++;
      $display("FAIL clean_miss: %0d mem txns, required one fill of 00002040", txq.size());
    end
    n_checks++;
    if (rd !== exp_rd || miss_cnt !== m_misses || hit_cnt !== m_hits) begin
      n_fail++;
      $display("FAIL clean_miss_data: rdata=%h miss=%0d hit=%0d, required %h %0d %0d",
               rd, miss_cnt, hit_cnt, exp_rd, m_misses, m_hits);
    end
  endtask

  task automatic test_idle();
    logic [31:0] h0, m0;
    h0 = hit_cnt;
    m0 = miss_cnt;
    resp_en  = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = 32'h5550;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    resp_en = 1'b1;
    n_checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || hit_cnt !== h0 || miss_cnt !== m0) begin
      n_fail++;
      $display("FAIL idle_quiet: stall=%b mem_req=%b hit=%0d miss=%0d, required 0 0 %0d %0d",
               stall, mem_req, hit_cnt, miss_cnt, h0, m0);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, wa, addr, wd;
    logic [MEM_W-1:0] wdat;
    bit hit, wb, to, we;
    int stalls, nexp, errs;
    errs = 0;
    for (int it = 0; it < 200; it++) begin
      we        = 1'($urandom_range(0, 1));
      addr      = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, LINES - 1)) << 4) |
                  32'($urandom_range(0, 15));
      wd        = $urandom;
      ack_delay = int'($urandom_range(1, 4));
      model_access(we, addr, wd, hit, wb, wa, wdat, exp_rd);
      access(we, addr, wd, rd, stalls, to);
      nexp = hit ? 0 : (wb ? 2 : 1);
      n_checks++;
      if (to || (hit && stalls != 0) || (!hit && stalls == 0) || txq.size() != nexp) begin
        n_fail++;
        errs++;
        $display("FAIL rand_txn[%0d] addr=%h: stalls=%0d txns=%0d, required hit=%b txns=%0d",
                 it, addr, stalls, txq.size(), hit, nexp);
      end else if (wb) begin
        n_checks++;
        if (txq[0].we != 1'b1 || txq[0].addr !== wa || txq[0].data !== wdat ||
            txq[1].we != 1'b0 || txq[1].addr !== {addr[31:4], 4'b0000}) begin
          n_fail++;
          errs++;
          $display("FAIL rand_wb[%0d]: wb addr=%h fill addr=%h, required %h %h",
                   it, txq[0].addr, txq[1].addr, wa, {addr[31:4], 4'b0000});
        end
      end else if (!hit) begin
        n_checks++;
        if (txq[0].we != 1'b0 || txq[0].addr !== {addr[31:4], 4'b0000}) begin
          n_fail++;
          errs++;
          $display("FAIL rand_fill[%0d]: addr=%h, required %h", it, txq[0].addr,
                   {addr[31:4], 4'b0000});
        end
      end
      if (!we) begin
        n_checks++;
        if (rd !== exp_rd) begin
          n_fail++;
          errs++;
          $display("FAIL rand_rdata[%0d] addr=%h: got %h, required %h", it, addr, rd, exp_rd);
        end
      end
      n_checks++;
      if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin
        n_fail++;
        errs++;
        $display("FAIL rand_counters[%0d]: hit=%0d miss=%0d, required %0d %0d",
                 it, hit_cnt, miss_cnt, m_hits, m_misses);
      end
      if (errs > 10) break;
    end
  endtask

  task automatic test_reset_mid_alloc();
    logic [31:0] rd, exp_rd, wa;
    logic [MEM_W-1:0] wdat;
    bit hit, wb, to;
    int stalls;
    ack_delay = 1;
    model_access(1'b0, 32'h6050, 32'h0, hit, wb, wa, wdat, exp_rd);
    access(1'b0, 32'h6050, 32'h0, rd, stalls, to);
    resp_en = 1'b0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h7050;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h7050) begin
      n_fail++;
      $display("FAIL alloc_pending: req=%b we=%b addr=%h, required 1 0 00007050",
               mem_req, mem_we, mem_addr);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b stall=%b hit=%0d miss=%0d, required all 0",
               mem_req, stall, hit_cnt, miss_cnt);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = '1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL late_ack: req=%b hit=%0d miss=%0d, required 0 0 0", mem_req, hit_cnt,
               miss_cnt);
    end
    model_reset();
    resp_en   = 1'b1;
    ack_delay = 2;
    model_access(1'b0, 32'h40, 32'h0, hit, wb, wa, wdat, exp_rd);
    access(1'b0, 32'h40, 32'h0, rd, stalls, to);
    n_checks++;
    if (to || stalls == 0 || txq.size() != 1 || miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_miss: stalls=%0d txns=%0d miss=%0d hit=%0d, required >0 1 1 0",
               stalls, txq.size(), miss_cnt, hit_cnt);
    end
    n_checks++;
    if (rd !== exp_rd) begin
      n_fail++;
      $display("FAIL post_reset_rdata: got %h, required %h", rd, exp_rd);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] rd, exp_rd, wa;
    logic [MEM_W-1:0] wdat;
    bit hit, wb, to;
    int stalls;
    @(negedge clk);
    force dut.r_miss_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_miss_cnt;
    #1;
    n_checks++;
    if (miss_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sat_preload: got %h, required ffffffff", miss_cnt);
    end
    model_access(1'b0, 32'h7090, 32'h0, hit, wb, wa, wdat, exp_rd);
    access(1'b0, 32'h7090, 32'h0, rd, stalls, to);
    n_checks++;
    if (to || stalls == 0 || miss_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sat_miss: stalls=%0d miss=%h, required >0 ffffffff", stalls, miss_cnt);
    end
    n_checks++;
    if (rd !== exp_rd || hit_cnt !== m_hits) begin
      n_fail++;
      $display("FAIL sat_side: rdata=%h hit=%0d, required %h %0d", rd, hit_cnt, exp_rd, m_hits);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h40;
    cpu_wdata = 32'h0;
    model_reset();
    test_reset();
    test_cold_read();
    test_hit();
    test_writeback();
    test_clean_miss();
    test_idle();
    test_random();
    test_reset_mid_alloc();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
